// File: rtl/clock_pkg.sv
// Shared constants for the wall-clock design: BCD digit widths, time-of-day
// limits and the default system clock rate. The display driver imports it too.
package clock_pkg;

    localparam int CLK_HZ_DEFAULT = 100_000_000;

    localparam int HR1_W  = 2;
    localparam int HR0_W  = 4;
    localparam int MIN1_W = 3;
    localparam int MIN0_W = 4;
    localparam int SEC1_W = 3;
    localparam int SEC0_W = 4;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    // Last legal value of each digit, derived from the limits above.
    localparam logic [3:0]        BCD_NINE  = 4'd9;
    localparam logic [SEC1_W-1:0] SEC1_LAST = SEC1_W'(SEC_MAX / 10);
    localparam logic [MIN1_W-1:0] MIN1_LAST = MIN1_W'(MIN_MAX / 10);
    localparam logic [HR1_W-1:0]  HR1_LAST  = HR1_W'(HR_MAX / 10);
    localparam logic [HR0_W-1:0]  HR0_LAST  = HR0_W'(HR_MAX % 10);

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-second tick. Freezes while En is
// low and restarts from zero whenever Clr is seen.
module tick_prescaler
    import clock_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT
)
(
    input  logic Clk,
    input  logic nReset,
    input  logic En,
    input  logic Clr,
    output logic Tick
);

    localparam int             CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] count;

    // The tick is only meaningful while counting; a frozen count never ticks.
    assign Tick = En && (count == LAST);

    // Free-running 0..CLK_HZ-1 counter with clear taking priority over enable.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            count <= '0;
        end else if (Clr) begin
            count <= '0;
        end else if (En) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/timekeeper_bcd.sv
// Time-of-day keeper in BCD. Advances once per second from the prescaler and
// takes single-cycle minute/hour set pulses; a button always beats a tick.
module timekeeper_bcd
    import clock_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT
)
(
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Run,
    input  logic              MinBtn,
    input  logic              HrBtn,
    output logic [HR1_W-1:0]  Hr1,
    output logic [HR0_W-1:0]  Hr0,
    output logic [MIN1_W-1:0] Min1,
    output logic [MIN0_W-1:0] Min0,
    output logic [SEC1_W-1:0] Sec1,
    output logic [SEC0_W-1:0] Sec0,
    output logic              SecTick
);

    logic tick;
    logic btn_any;
    logic advance;
    logic sec_carry;
    logic min_carry;
    logic min_inc;
    logic hr_inc;

    logic [HR1_W-1:0]  hr1_next;
    logic [HR0_W-1:0]  hr0_next;
    logic [MIN1_W-1:0] min1_next;
    logic [MIN0_W-1:0] min0_next;
    logic [SEC1_W-1:0] sec1_next;
    logic [SEC0_W-1:0] sec0_next;

    assign btn_any = MinBtn | HrBtn;

    tick_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .Clk    (Clk),
        .nReset (nReset),
        .En     (Run),
        .Clr    (btn_any),
        .Tick   (tick)
    );

    // A tick that collides with a button is dropped together with its carries.
    assign advance   = tick & ~btn_any;
    assign sec_carry = (Sec1 == SEC1_LAST) && (Sec0 == BCD_NINE);
    assign min_carry = (Min1 == MIN1_LAST) && (Min0 == BCD_NINE);
    assign min_inc   = MinBtn | (advance & sec_carry);
    assign hr_inc    = HrBtn  | (advance & sec_carry & min_carry);

    // Digit chain: each pair increments or clears, carrying only on time advance.
    always_comb begin
        hr1_next  = Hr1;
        hr0_next  = Hr0;
        min1_next = Min1;
        min0_next = Min0;
        sec1_next = Sec1;
        sec0_next = Sec0;

        if (btn_any) begin
            sec1_next = '0;
            sec0_next = '0;
        end else if (advance) begin
            if (Sec0 == BCD_NINE) begin
                sec0_next = '0;
                sec1_next = (Sec1 == SEC1_LAST) ? '0 : Sec1 + SEC1_W'(1);
            end else begin
                sec0_next = Sec0 + SEC0_W'(1);
            end
        end

        if (min_inc) begin
            if (Min0 == BCD_NINE) begin
                min0_next = '0;
                min1_next = (Min1 == MIN1_LAST) ? '0 : Min1 + MIN1_W'(1);
            end else begin
                min0_next = Min0 + MIN0_W'(1);
            end
        end

        if (hr_inc) begin
            if ((Hr1 == HR1_LAST) && (Hr0 == HR0_LAST)) begin
                hr1_next = '0;
                hr0_next = '0;
            end else if (Hr0 == BCD_NINE) begin
                hr0_next = '0;
                hr1_next = Hr1 + HR1_W'(1);
            end else begin
                hr0_next = Hr0 + HR0_W'(1);
            end
        end
    end

    // Register every output so nothing combinational reaches the display.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Hr1     <= '0;
            Hr0     <= '0;
            Min1    <= '0;
            Min0    <= '0;
            Sec1    <= '0;
            Sec0    <= '0;
            SecTick <= 1'b0;
        end else begin
            Hr1     <= hr1_next;
            Hr0     <= hr0_next;
            Min1    <= min1_next;
            Min0    <= min0_next;
            Sec1    <= sec1_next;
            Sec0    <= sec0_next;
            SecTick <= advance;
        end
    end

endmodule

// File: tb/tb_timekeeper_bcd.sv
// Bench for timekeeper_bcd: directed scenarios plus random traffic, checked by
// a seconds-of-day reference model through a scoreboard queue.
module tb_timekeeper_bcd;

    localparam int CLK_HZ = 4;
    localparam int DAY    = 86400;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       run;
    logic       min_btn;
    logic       hr_btn;
    logic [1:0] hr1;
    logic [3:0] hr0;
    logic [2:0] min1;
    logic [3:0] min0;
    logic [2:0] sec1;
    logic [3:0] sec0;
    logic       sec_tick;

    typedef struct {
        int h1;
        int h0;
        int m1;
        int m0;
        int s1;
        int s0;
        int tk;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   m_tod;
    int   m_pre;
    int   total;
    int   bad;
    int   ticks_seen;

    timekeeper_bcd #(
        .CLK_HZ (CLK_HZ)
    ) dut (
        .Clk     (clk),
        .nReset  (n_reset),
        .Run     (run),
        .MinBtn  (min_btn),
        .HrBtn   (hr_btn),
        .Hr1     (hr1),
        .Hr0     (hr0),
        .Min1    (min1),
        .Min0    (min0),
        .Sec1    (sec1),
        .Sec0    (sec0),
        .SecTick (sec_tick)
    );

    always #5 clk = ~clk;

    function automatic exp_t to_exp(input int tod, input int tk);
        exp_t e;
        int   h;
        int   m;
        int   s;
        h    = tod / 3600;
        m    = (tod / 60) % 60;
        s    = tod % 60;
        e.h1 = h / 10;
        e.h0 = h % 10;
        e.m1 = m / 10;
        e.m0 = m % 10;
        e.s1 = s / 10;
        e.s0 = s % 10;
        e.tk = tk;
        return e;
    endfunction

    task automatic check_output(input string name, input exp_t e);
        total++;
        if (int'(hr1) != e.h1 || int'(hr0) != e.h0 || int'(min1) != e.m1 ||
            int'(min0) != e.m0 || int'(sec1) != e.s1 || int'(sec0) != e.s0 ||
            int'(sec_tick) != e.tk) begin
            bad++;
            $display("[TB] FAIL %s @%0t: got %0d%0d:%0d%0d:%0d%0d tick=%0d, want %0d%0d:%0d%0d:%0d%0d tick=%0d",
                     name, $time, hr1, hr0, min1, min0, sec1, sec0, sec_tick,
                     e.h1, e.h0, e.m1, e.m0, e.s1, e.s0, e.tk);
        end
    endtask

    // Drive one cycle of inputs now, advance the model and queue the expectation.
    task automatic step_now(input logic r, input logic mb, input logic hb);
        int h;
        int m;
        int tk;
        run     = r;
        min_btn = mb;
        hr_btn  = hb;
        tk      = 0;
        if (mb || hb) begin
            h = m_tod / 3600;
            m = (m_tod / 60) % 60;
            if (mb) m = (m + 1) % 60;
            if (hb) h = (h + 1) % 24;
            m_tod = h * 3600 + m * 60;
            m_pre = 0;
        end else if (r) begin
            if (m_pre == CLK_HZ - 1) begin
                m_pre = 0;
                m_tod = (m_tod + 1) % DAY;
                tk    = 1;
            end else begin
                m_pre = m_pre + 1;
            end
        end
        sb_q.push_back(to_exp(m_tod, tk));
    endtask

    task automatic apply_stimulus(input logic r, input logic mb, input logic hb);
        @(negedge clk);
        step_now(r, mb, hb);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic press_min(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b1, 1'b0);
    endtask

    task automatic press_hr(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
    endtask

    // Compare against a hand-written time right after the next clock edge.
    task automatic check_time(input string name, input int h, input int m,
                              input int s, input int tk);
        @(posedge clk);
        #2;
        check_output(name, to_exp(h * 3600 + m * 60 + s, tk));
    endtask

    // Assert reset between edges, confirm it acts at once, then release.
    task automatic do_reset(input string name);
        @(posedge clk);
        #3;
        n_reset = 1'b0;
        #1;
        m_tod = 0;
        m_pre = 0;
        check_output(name, to_exp(0, 0));
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        step_now(1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: every edge that has an outstanding expectation gets compared.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check_output("cycle", mon_e);
        end
    end

    // Count SecTick pulses so frozen periods can be checked for silence.
    always @(posedge clk) begin
        #1;
        if (sec_tick === 1'b1) ticks_seen++;
    end

    initial begin
        n_reset    = 1'b0;
        run        = 1'b0;
        min_btn    = 1'b0;
        hr_btn     = 1'b0;
        total      = 0;
        bad        = 0;
        ticks_seen = 0;
        m_tod      = 0;
        m_pre      = 0;

        #12;
        check_output("reset_state", to_exp(0, 0));
        @(negedge clk);
        n_reset = 1'b1;
        step_now(1'b1, 1'b0, 1'b0);

        // Reach 12:34:56 and stop mid-count before pulling reset.
        press_hr(12);
        press_min(34);
        run_cycles(56 * CLK_HZ);
        run_cycles(2);
        do_reset("reset_async");
        run_cycles(2);
        check_time("reset_no_early_tick", 0, 0, 0, 0);
        run_cycles(1);
        check_time("reset_first_tick", 0, 0, 1, 1);

        // Full-day rollover.
        press_hr(23);
        press_min(59);
        run_cycles(59 * CLK_HZ);
        check_time("pre_rollover", 23, 59, 59, 1);
        run_cycles(CLK_HZ);
        check_time("rollover", 0, 0, 0, 1);

        // Minute wrap without hour carry.
        press_hr(12);
        press_min(59);
        run_cycles(30 * CLK_HZ);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_time("min_wrap", 12, 0, 0, 0);
        run_cycles(3);
        check_time("min_wrap_no_tick", 12, 0, 0, 0);
        run_cycles(1);
        check_time("min_wrap_first_tick", 12, 0, 1, 1);

        // Hour wrap at 23:15:07.
        press_hr(11);
        press_min(15);
        run_cycles(7 * CLK_HZ);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        check_time("hr_wrap", 0, 15, 0, 0);

        // Minute button colliding with a tick at 00:00:03.
        press_min(45);
        run_cycles(3 * CLK_HZ);
        run_cycles(CLK_HZ - 1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_time("min_tick_collision", 0, 1, 0, 0);

        // Both buttons at 23:59:02.
        press_hr(23);
        press_min(58);
        run_cycles(2 * CLK_HZ);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        check_time("dual_btn_wrap", 0, 0, 0, 0);

        // Freeze mid-count, then resume from the held count.
        run_cycles(CLK_HZ + 2);
        ticks_seen = 0;
        for (int i = 0; i < 20; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
        check_time("freeze_hold", 0, 0, 1, 0);
        total++;
        if (ticks_seen != 0) begin
            bad++;
            $display("[TB] FAIL freeze_no_tick: saw %0d ticks, want 0", ticks_seen);
        end
        run_cycles(CLK_HZ - 2);
        check_time("freeze_resume", 0, 0, 2, 1);

        // Hour button while frozen still acts and clears the prescaler.
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
        check_time("freeze_hr_btn", 1, 0, 0, 0);
        run_cycles(CLK_HZ);
        check_time("freeze_restart", 1, 0, 1, 1);

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            int   b;
            logic r;
            r = ($urandom_range(0, 7) != 0);
            b = $urandom_range(0, 15);
            apply_stimulus(r, (b == 0) || (b == 1), (b == 1) || (b == 2));
            if (i % 600 == 599) do_reset("rand_reset");
        end

        @(posedge clk);
        #3;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL queue_drain: %0d entries left, want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timekeeper_bcd.md
# timekeeper_bcd

Downstream consumer of the button debouncers in the wall-clock design. It keeps time of day as BCD hours, minutes and seconds, advancing once per second from a prescaled system clock. The single-cycle press pulses from the debouncers set minutes and hours. Its BCD outputs feed the seven-segment display driver.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency; one second equals `CLK_HZ` cycles (minimum 2).
- `Clk` in 1: system clock, rising edge.
- `nReset` in 1: asynchronous, active-low reset. Assertion takes effect immediately; deassertion is sampled on `Clk`.
- `Run` in 1: high lets time advance; low freezes the prescaler.
- `MinBtn` in 1: one-cycle pulse from the minute debouncer.
- `HrBtn` in 1: one-cycle pulse from the hour debouncer.
- `Hr1` out 2: hours tens digit, 0–2.
- `Hr0` out 4: hours ones digit, 0–9.
- `Min1` out 3: minutes tens digit, 0–5.
- `Min0` out 4: minutes ones digit, 0–9.
- `Sec1` out 3: seconds tens digit, 0–5.
- `Sec0` out 4: seconds ones digit, 0–9.
- `SecTick` out 1: one-cycle pulse, asserted in the cycle the seconds value changes due to time advance.

## Operation
- **Reset.** `nReset` low:
  - all digit outputs go to 0 (display reads 00:00:00);
  - the prescaler goes to 0;
  - `SecTick` goes to 0.
- **Prescaler.** Counts 0..`CLK_HZ`-1 while `Run`=1; holds its value while `Run`=0.
  - Internal `tick` is true in the cycle the count equals `CLK_HZ`-1; the count then wraps to 0.
  - Width: $clog2(`CLK_HZ`).
- **Time advance on `tick`, when no button pulse is present:**
  - `Sec0` increments.
  - 9 → 0, carry into `Sec1`; 59 → 00, carry into the minutes.
  - Minutes roll 59 → 00 and carry into the hours.
  - Hours roll 23 → 00.
  - 23:59:59 → 00:00:00 in a single edge.
- **`MinBtn`=1:**
  - Minutes increment modulo 60, with no carry into the hours.
  - Seconds clear to 00 and the prescaler clears to 0.
- **`HrBtn`=1:**
  - Hours increment modulo 24 (23 → 00).
  - Seconds clear to 00 and the prescaler clears to 0.
- **Simultaneous events:**
  - `MinBtn` and `HrBtn` in the same cycle: both increments apply independently, so 23:59 → 00:00 with no cross-carry.
  - A button pulse coinciding with `tick`: the button wins. The tick, and any carry it would produce, is discarded, and `SecTick` stays 0.
- **Buttons with `Run`=0:** buttons still act, and the prescaler still clears.
- **Button width:** inputs are assumed to be one-cycle pulses. A pulse held for N cycles produces N increments; there is no internal edge detection.
- **Digit validity:** digits are always valid BCD. Hours 24–29 are unreachable, and no illegal digit state can be entered.

## Timing
- All outputs are registered and update on the `Clk` edge that samples the event; latency from event to output is one cycle.
- `SecTick` is high in the same cycle the new seconds value is visible.
  - Period is `CLK_HZ` cycles with `Run` held high and no buttons pressed.
  - The first tick arrives `CLK_HZ` cycles after reset release or after a button clear.
- Reset asserted mid-count discards any pending tick or carry; outputs show 00:00:00 while `nReset` is low.
- No combinational path from any input to any output.

## Structure
- **Shared package `clock_pkg`:**
  - digit widths (2/4/3/4/3/4);
  - limit constants: `SEC_MAX`=59, `MIN_MAX`=59, `HR_MAX`=23;
  - `CLK_HZ` default.
  - The display driver imports the same package.
- **Sub-module `tick_prescaler`:**
  - parameter `CLK_HZ`;
  - inputs `Clk`, `nReset`, `En`, `Clr`;
  - output `Tick`.
- **BCD digit chain:** kept in the top module as explicit carry logic per digit pair.

## Test plan
All scenarios use `CLK_HZ`=4.
- **Reset:** assert `nReset` low mid-count at 12:34:56 → all digits 0 immediately, `SecTick`=0. Release → first `SecTick` exactly 4 cycles later, display 00:00:01.
- **Rollover:** preload via buttons to 23:59, then tick 59 times → 23:59:59. Next tick → 00:00:00 with `SecTick`=1.
- **Minute wrap:** `MinBtn` at 12:59:30 → 12:00:00, hours unchanged. Next `SecTick` arrives 4 cycles after the press.
- **Hour wrap:** `HrBtn` at 23:15:07 → 00:15:00.
- **Collision:**
  - `MinBtn` and `tick` in the same cycle at 00:00:03 → 00:01:00, `SecTick`=0;
  - `MinBtn`+`HrBtn` together at 23:59:xx → 00:00:00.
- **Freeze:** `Run`=0 for 20 cycles → no `SecTick`, prescaler holds. `HrBtn` during the freeze still increments the hour. On `Run`=1 the count resumes from 0.
